// File: rtl/count_ctrl.sv
// -----------------------------------------------------------------------------
// count_ctrl
//
// Sequencer for the up-counter datapath. It owns the count register and runs
// a programmable run of `limit` ticks. One tick occurs every `prescale`+1
// clock cycles. Progress is reported on `busy`, on `count` and on a one-cycle
// `done` pulse.
//
// Optional feature: define COUNT_CTRL_AUTORELOAD_EN to make DONE restart the
// run automatically with the latched limit/prescale. This produces a periodic
// `done`. `stop` ends the sequence. When the macro is not defined, DONE always
// returns to IDLE.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request to begin a run (level-sampled, honoured in IDLE only)
//   stop      abort request (wins over start and over a tick)
//   limit     terminal count, latched on an accepted start
//   prescale  tick divider P, latched on an accepted start
//   busy      high in RUN and DONE
//   done      one-cycle pulse, decode of the DONE state
//   count     current count register
// -----------------------------------------------------------------------------
module count_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]      COUNT_ONE = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PC_ONE    = PRESCALE_W'(1);

  state_t                state;
  logic [PRESCALE_W-1:0] pc;
  logic [WIDTH-1:0]      limit_q;
  logic [PRESCALE_W-1:0] prescale_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      pc         <= '0;
      limit_q    <= '0;
      prescale_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          // The count from the previous run stays visible while idle.
          if (start && !stop) begin
            limit_q    <= limit;
            prescale_q <= prescale;
            count      <= '0;
            pc         <= '0;
            state      <= (limit == '0) ? DONE : RUN;
          end
        end

        RUN: begin
          if (stop) begin
            state <= IDLE;          // count and pc freeze where they are
          end else if (pc == prescale_q) begin
            pc    <= '0;
            count <= count + COUNT_ONE;
            // count < limit_q here, so count+1 cannot wrap
            if (count + COUNT_ONE == limit_q) begin
              state <= DONE;
            end
          end else begin
            pc <= pc + PC_ONE;
          end
        end

        DONE: begin
`ifdef COUNT_CTRL_AUTORELOAD_EN
          if (stop) begin
            state <= IDLE;
          end else if (limit_q == '0) begin
            state <= DONE;          // zero-length period: done held high
          end else begin
            count <= '0;
            pc    <= '0;
            state <= RUN;
          end
`else
          state <= IDLE;
`endif
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Both outputs are pure decodes of the state register.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_count_ctrl.sv
// -----------------------------------------------------------------------------
// tb_count_ctrl
//
// Directed bench for count_ctrl. A behavioural model tracks each run as
// "edges elapsed since the start was accepted". From that value it derives
// the expected count (ticks = elapsed / (P+1), capped at L) and the expected
// done cycle (elapsed == L*(P+1)). A compare process checks the DUT against
// the model on every falling clock edge. Hand-computed literal checks at
// chosen points in each scenario pin the model itself.
// -----------------------------------------------------------------------------
module tb_count_ctrl;

  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic                  stop;
  logic [WIDTH-1:0]      limit;
  logic [PRESCALE_W-1:0] prescale;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      count;

  int checks = 0;
  int errors = 0;

  count_ctrl #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .limit    (limit),
    .prescale (prescale),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  bit m_busy;
  bit m_done;
  int m_t;       // edges elapsed in the current run since acceptance
  int m_l;
  int m_p;
  int m_count;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 0;
      m_done  = 0;
      m_t     = 0;
      m_l     = 0;
      m_p     = 0;
      m_count = 0;
    end else if (!m_busy) begin
      if (start && !stop) begin
        m_l     = int'(limit);
        m_p     = int'(prescale);
        m_t     = 0;
        m_count = 0;
        m_busy  = 1;
        m_done  = (m_l == 0);
      end
    end else if (m_done) begin
`ifdef COUNT_CTRL_AUTORELOAD_EN
      if (stop) begin
        m_busy = 0;
        m_done = 0;
      end else if (m_l != 0) begin
        m_t     = 0;
        m_count = 0;
        m_done  = 0;
      end
`else
      m_busy = 0;
      m_done = 0;
`endif
    end else begin
      if (stop) begin
        m_busy = 0;
      end else begin
        m_t     = m_t + 1;
        m_count = m_t / (m_p + 1);
        if (m_count > m_l) m_count = m_l;
        m_done  = (m_t == m_l * (m_p + 1));
      end
    end
  end

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison against the model, on the falling edge.
  always @(negedge clk) begin
    chk("model_busy",  int'(busy),  int'(m_busy));
    chk("model_done",  int'(done),  int'(m_done));
    chk("model_count", int'(count), m_count);
  end

  // ------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a start pulse. On return we are just after edge e0.
  task automatic launch(input int l, input int p);
    limit    = WIDTH'(l);
    prescale = PRESCALE_W'(p);
    start    = 1'b1;
    step();
    start    = 1'b0;
    // later input changes must not affect the accepted run
    limit    = WIDTH'($urandom);
    prescale = PRESCALE_W'($urandom);
    $display("txn start L=%0d P=%0d busy=%0b count=%0d", l, p, busy, count);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    limit    = '0;
    prescale = '0;
    #12;
    chk("reset_busy",  int'(busy),  0);
    chk("reset_done",  int'(done),  0);
    chk("reset_count", int'(count), 0);
    step();
    rst_n = 1'b1;
    step();

    // L=3, P=0
    launch(3, 0);
    chk("t1_busy_e0", int'(busy), 1);
    chk("t1_count_e0", int'(count), 0);
    step(); chk("t1_count_e1", int'(count), 1);
    step(); chk("t1_count_e2", int'(count), 2);
    step(); chk("t1_count_e3", int'(count), 3); chk("t1_done_e3", int'(done), 1);
    step(); chk("t1_busy_e4", int'(busy), 0); chk("t1_done_e4", int'(done), 0);
    chk("t1_count_hold", int'(count), 3);
    $display("txn L=3 P=0 end busy=%0b count=%0d", busy, count);

    // L=2, P=2
    launch(2, 2);
    repeat (2) step();
    chk("t2_count_e2", int'(count), 0);
    step(); chk("t2_count_e3", int'(count), 1);
    repeat (2) step();
    chk("t2_done_e5", int'(done), 0);
    step(); chk("t2_count_e6", int'(count), 2); chk("t2_done_e6", int'(done), 1);
    step(); chk("t2_busy_e7", int'(busy), 0);
    $display("txn L=2 P=2 end busy=%0b count=%0d", busy, count);

    // L=0
    launch(0, 5);
    chk("t3_done_e0", int'(done), 1);
    chk("t3_count_e0", int'(count), 0);
    step(); chk("t3_busy_e1", int'(busy), 0);
    $display("txn L=0 end busy=%0b count=%0d", busy, count);

    // L=5, P=0, stop after count reaches 3
    launch(5, 0);
    repeat (3) step();
    chk("t4_count_e3", int'(count), 3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t4_busy_stop", int'(busy), 0);
    chk("t4_count_stop", int'(count), 3);
    chk("t4_done_stop", int'(done), 0);
    start = 1'b1; stop = 1'b1; limit = 8'd4;
    step();
    start = 1'b0; stop = 1'b0;
    chk("t4_startstop_busy", int'(busy), 0);
    chk("t4_startstop_count", int'(count), 3);
    $display("txn L=5 stop busy=%0b count=%0d", busy, count);

    // L=255, P=15 with ignored start pulses
    launch(255, 15);
    for (int i = 1; i < 4080; i++) begin
      start = (i % 97 == 5);
      step();
    end
    start = 1'b0;
    chk("t5_count_e4079", int'(count), 254);
    chk("t5_done_e4079", int'(done), 0);
    step();
    chk("t5_done_e4080", int'(done), 1);
    chk("t5_count_e4080", int'(count), 255);
    step(); chk("t5_busy_e4081", int'(busy), 0);
    $display("txn L=255 P=15 end busy=%0b count=%0d", busy, count);

    // Asynchronous reset mid-run, L=10, P=1
    launch(10, 1);
    repeat (7) step();
    chk("t6_count_e7", int'(count), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_done", int'(done), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_after_busy", int'(busy), 0);
    $display("txn reset mid-run busy=%0b count=%0d", busy, count);

`ifdef COUNT_CTRL_AUTORELOAD_EN
    // Periodic done, then stop
    launch(2, 0);
    repeat (2) step();
    chk("t7_done_first", int'(done), 1);
    repeat (7) step();
    chk("t7_busy_run", int'(busy), 1);
    stop = 1'b1;
    repeat (2) step();
    stop = 1'b0;
    chk("t7_busy_stopped", int'(busy), 0);
    $display("txn autoreload end busy=%0b count=%0d", busy, count);
`endif

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
